// File: rtl/p405s_sm_div32_seq.sv
// Sequential 32-bit signed/unsigned divider, one quotient bit per cycle
// using a 33-bit non-restoring add/subtract over the partial remainder.
// Ports:
//   CB, RESET            clock, synchronous active-high reset
//   START, SIGNED        divide request and signedness (captured together)
//   DIVIDEND, DIVISOR    32-bit operands captured with START
//   BUSY, DONE           in-progress flag, one-cycle completion pulse
//   QUOTIENT, REMAINDER  held results
//   DIV_ZERO, OVERFLOW   held exception flags
module p405s_sm_div32_seq (
  input  logic        CB,
  input  logic        RESET,
  input  logic        START,
  input  logic        SIGNED,
  input  logic [31:0] DIVIDEND,
  input  logic [31:0] DIVISOR,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] QUOTIENT,
  output logic [31:0] REMAINDER,
  output logic        DIV_ZERO,
  output logic        OVERFLOW
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        sgn_r;
  logic [31:0] dvd_r;
  logic [31:0] dvs_r;
  logic [31:0] dvs_mag;
  logic [32:0] pr;
  logic [31:0] q;
  logic        q_neg;
  logic        r_neg;
  logic        dz;
  logic        ov;

  logic [32:0] shl;
  logic [32:0] addend;
  logic [32:0] sum;
  logic [31:0] rem_mag;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic        a_neg;
  logic        b_neg;

  // Operand signs only matter for a signed divide.
  assign a_neg = sgn_r & dvd_r[31];
  assign b_neg = sgn_r & dvs_r[31];

  always_comb begin
    shl     = {pr[31:0], q[31]};
    // Non-negative remainder subtracts (~d + 1), negative adds d back.
    addend  = pr[32] ? {1'b0, dvs_mag} : ~{1'b0, dvs_mag};
    sum     = shl + addend + {32'd0, ~pr[32]};
    // Final restore fits in 32 bits: the corrected remainder is < divisor.
    rem_mag = pr[32] ? (pr[31:0] + dvs_mag) : pr[31:0];
    q_fin   = q_neg ? (~q + 32'd1) : q;
    r_fin   = r_neg ? (~rem_mag + 32'd1) : rem_mag;
    if (dz) begin
      q_fin = 32'hFFFF_FFFF;
      r_fin = dvd_r;
    end else if (ov) begin
      q_fin = 32'h8000_0000;
      r_fin = 32'd0;
    end
  end

  always_ff @(posedge CB) begin
    if (RESET) begin
      state     <= S_IDLE;
      cnt       <= 5'd0;
      sgn_r     <= 1'b0;
      dvd_r     <= 32'd0;
      dvs_r     <= 32'd0;
      dvs_mag   <= 32'd0;
      pr        <= 33'd0;
      q         <= 32'd0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      dz        <= 1'b0;
      ov        <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      QUOTIENT  <= 32'd0;
      REMAINDER <= 32'd0;
      DIV_ZERO  <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          DONE <= 1'b0;
          if (START) begin
            sgn_r <= SIGNED;
            dvd_r <= DIVIDEND;
            dvs_r <= DIVISOR;
            BUSY  <= 1'b1;
            state <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          q       <= a_neg ? (~dvd_r + 32'd1) : dvd_r;
          dvs_mag <= b_neg ? (~dvs_r + 32'd1) : dvs_r;
          q_neg   <= a_neg ^ b_neg;
          r_neg   <= a_neg;
          dz      <= (dvs_r == 32'd0);
          ov      <= sgn_r & (dvd_r == 32'h8000_0000)
                     & (dvs_r == 32'hFFFF_FFFF);
          pr      <= 33'd0;
          cnt     <= 5'd0;
          state   <= S_ITER;
        end
        S_ITER: begin
          pr  <= sum;
          q   <= {q[30:0], ~sum[32]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          QUOTIENT  <= q_fin;
          REMAINDER <= r_fin;
          DIV_ZERO  <= dz;
          OVERFLOW  <= ov;
          BUSY      <= 1'b0;
          DONE      <= 1'b1;
          state     <= S_DONE;
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p405s_sm_div32_seq.sv
// Directed self-checking bench for p405s_sm_div32_seq.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_p405s_sm_div32_seq;

  logic        CB;
  logic        RESET;
  logic        START;
  logic        SIGNED;
  logic [31:0] DIVIDEND;
  logic [31:0] DIVISOR;
  logic        BUSY;
  logic        DONE;
  logic [31:0] QUOTIENT;
  logic [31:0] REMAINDER;
  logic        DIV_ZERO;
  logic        OVERFLOW;

  int tests;
  int fails;

  p405s_sm_div32_seq dut (
    .CB(CB),
    .RESET(RESET),
    .START(START),
    .SIGNED(SIGNED),
    .DIVIDEND(DIVIDEND),
    .DIVISOR(DIVISOR),
    .BUSY(BUSY),
    .DONE(DONE),
    .QUOTIENT(QUOTIENT),
    .REMAINDER(REMAINDER),
    .DIV_ZERO(DIV_ZERO),
    .OVERFLOW(OVERFLOW)
  );

  initial CB = 1'b0;
  always #5 CB = ~CB;

  // Called at a falling edge: present operands, pulse START over one rising edge.
  task automatic go(input logic [31:0] a, input logic [31:0] b,
                    input logic s);
    DIVIDEND = a;
    DIVISOR  = b;
    SIGNED   = s;
    START    = 1'b1;
    @(posedge CB);
    #1 START = 1'b0;
  endtask

  // Count falling edges after the START edge until DONE, bounded.
  task automatic wait_done(output int lat, output int busy);
    lat  = 0;
    busy = 0;
    do begin
      @(negedge CB);
      lat++;
      if (BUSY) busy++;
    end while (!DONE && lat < 80);
  endtask

  task automatic test_reset;
    @(negedge CB);
    RESET = 1'b1;
    START = 1'b1;
    DIVIDEND = 32'd100;
    DIVISOR = 32'd7;
    @(negedge CB);
    @(negedge CB);
    START = 1'b0;
    RESET = 1'b0;
    tests++;
    if ({BUSY, DONE, DIV_ZERO, OVERFLOW} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags got=%b want=0000",
               {BUSY, DONE, DIV_ZERO, OVERFLOW});
    end
    tests++;
    if ({QUOTIENT, REMAINDER} !== 64'd0) begin
      fails++;
      $display("FAIL reset_results got q=%h r=%h want 0/0",
               QUOTIENT, REMAINDER);
    end
    @(negedge CB);
    tests++;
    if (BUSY !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle busy=%b want 0", BUSY);
    end
  endtask

  task automatic test_unsigned;
    int lat, busy;
    @(negedge CB);
    go(32'd100, 32'd7, 1'b0);
    wait_done(lat, busy);
    tests++;
    if (lat !== 35) begin
      fails++;
      $display("FAIL unsigned_latency got=%0d want=35", lat);
    end
    tests++;
    if (busy !== 34) begin
      fails++;
      $display("FAIL unsigned_busy got=%0d want=34", busy);
    end
    tests++;
    if (BUSY !== 1'b0) begin
      fails++;
      $display("FAIL busy_with_done got=%b want 0", BUSY);
    end
    tests++;
    if ({QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW} !==
        {32'd14, 32'd2, 2'b00}) begin
      fails++;
      $display("FAIL unsigned_100_7 got q=%h r=%h dz=%b ov=%b want 14/2",
               QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW);
    end
    @(negedge CB);
    tests++;
    if (DONE !== 1'b0 || QUOTIENT !== 32'd14) begin
      fails++;
      $display("FAIL done_pulse_hold done=%b q=%h want 0/14",
               DONE, QUOTIENT);
    end
  endtask

  task automatic test_signed;
    int lat, busy;
    @(negedge CB);
    go(32'hFFFF_FF9C, 32'd7, 1'b1);
    wait_done(lat, busy);
    tests++;
    if ({QUOTIENT, REMAINDER} !== {32'hFFFF_FFF2, 32'hFFFF_FFFE}) begin
      fails++;
      $display("FAIL signed_m100_7 got q=%h r=%h want fffffff2/fffffffe",
               QUOTIENT, REMAINDER);
    end
    @(negedge CB);
    go(32'd100, 32'hFFFF_FFF9, 1'b1);
    wait_done(lat, busy);
    tests++;
    if ({QUOTIENT, REMAINDER} !== {32'hFFFF_FFF2, 32'd2}) begin
      fails++;
      $display("FAIL signed_100_m7 got q=%h r=%h want fffffff2/2",
               QUOTIENT, REMAINDER);
    end
    @(negedge CB);
    go(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
    wait_done(lat, busy);
    tests++;
    if ({QUOTIENT, REMAINDER} !== {32'd14, 32'hFFFF_FFFE}) begin
      fails++;
      $display("FAIL signed_m100_m7 got q=%h r=%h want e/fffffffe",
               QUOTIENT, REMAINDER);
    end
  endtask

  task automatic test_corners;
    int lat, busy;
    @(negedge CB);
    go(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(lat, busy);
    tests++;
    if ({QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW} !==
        {32'hFFFF_FFFF, 32'd0, 2'b00}) begin
      fails++;
      $display("FAIL max_div_1 got q=%h r=%h dz=%b ov=%b",
               QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW);
    end
    @(negedge CB);
    go(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    wait_done(lat, busy);
    tests++;
    if ({QUOTIENT, REMAINDER} !== {32'd1, 32'd1}) begin
      fails++;
      $display("FAIL max_div_big got q=%h r=%h want 1/1",
               QUOTIENT, REMAINDER);
    end
    @(negedge CB);
    go(32'd5, 32'd0, 1'b0);
    wait_done(lat, busy);
    tests++;
    if (lat !== 35 || {QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW} !==
        {32'hFFFF_FFFF, 32'd5, 2'b10}) begin
      fails++;
      $display("FAIL div_zero lat=%0d q=%h r=%h dz=%b ov=%b",
               lat, QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW);
    end
    @(negedge CB);
    go(32'hFFFF_FFFB, 32'd0, 1'b1);
    wait_done(lat, busy);
    tests++;
    if ({QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW} !==
        {32'hFFFF_FFFF, 32'hFFFF_FFFB, 2'b10}) begin
      fails++;
      $display("FAIL signed_div_zero q=%h r=%h dz=%b ov=%b",
               QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW);
    end
    @(negedge CB);
    go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, busy);
    tests++;
    if ({QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW} !==
        {32'h8000_0000, 32'd0, 2'b01}) begin
      fails++;
      $display("FAIL overflow q=%h r=%h dz=%b ov=%b",
               QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW);
    end
    @(negedge CB);
    go(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat, busy);
    tests++;
    if ({QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW} !==
        {32'd0, 32'h8000_0000, 2'b00}) begin
      fails++;
      $display("FAIL unsigned_no_ovf q=%h r=%h dz=%b ov=%b",
               QUOTIENT, REMAINDER, DIV_ZERO, OVERFLOW);
    end
  endtask

  task automatic test_busy_ignore;
    int lat, extra;
    @(negedge CB);
    go(32'd100, 32'd7, 1'b0);
    lat = 0;
    do begin
      @(negedge CB);
      lat++;
      if (lat == 10) begin
        DIVIDEND = 32'd50;
        DIVISOR  = 32'd5;
        START    = 1'b1;
      end else begin
        START = 1'b0;
      end
    end while (!DONE && lat < 80);
    tests++;
    if (lat !== 35 || {QUOTIENT, REMAINDER} !== {32'd14, 32'd2}) begin
      fails++;
      $display("FAIL busy_ignore lat=%0d q=%h r=%h want 35 14/2",
               lat, QUOTIENT, REMAINDER);
    end
    extra = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge CB);
      if (DONE || BUSY) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL busy_ignore_extra got=%0d want=0", extra);
    end
  endtask

  task automatic test_back_to_back;
    int lat, busy, held_bad;
    @(negedge CB);
    go(32'd100, 32'd7, 1'b0);
    wait_done(lat, busy);
    tests++;
    if ({QUOTIENT, REMAINDER} !== {32'd14, 32'd2}) begin
      fails++;
      $display("FAIL b2b_first got q=%h r=%h want 14/2",
               QUOTIENT, REMAINDER);
    end
    go(32'd9, 32'd4, 1'b0);
    lat = 0;
    held_bad = 0;
    do begin
      @(negedge CB);
      lat++;
      if (lat == 1 && BUSY !== 1'b1) held_bad++;
      if (!DONE && {QUOTIENT, REMAINDER} !== {32'd14, 32'd2})
        held_bad++;
    end while (!DONE && lat < 80);
    tests++;
    if (lat !== 35) begin
      fails++;
      $display("FAIL b2b_latency got=%0d want=35", lat);
    end
    tests++;
    if (held_bad !== 0) begin
      fails++;
      $display("FAIL b2b_hold got=%0d bad cycles want=0", held_bad);
    end
    tests++;
    if ({QUOTIENT, REMAINDER} !== {32'd2, 32'd1}) begin
      fails++;
      $display("FAIL b2b_second got q=%h r=%h want 2/1",
               QUOTIENT, REMAINDER);
    end
  endtask

  task automatic test_reset_mid;
    int lat, busy, extra;
    @(negedge CB);
    go(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 20; i++) @(negedge CB);
    RESET = 1'b1;
    @(negedge CB);
    RESET = 1'b0;
    tests++;
    if ({BUSY, DONE, DIV_ZERO, OVERFLOW, QUOTIENT, REMAINDER} !== 68'd0)
    begin
      fails++;
      $display("FAIL reset_mid busy=%b done=%b q=%h r=%h want all 0",
               BUSY, DONE, QUOTIENT, REMAINDER);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CB);
      if (DONE || BUSY) extra++;
    end
    tests++;
    if (extra !== 0) begin
      fails++;
      $display("FAIL reset_mid_no_done got=%0d want=0", extra);
    end
    go(32'd100, 32'd7, 1'b0);
    wait_done(lat, busy);
    tests++;
    if (lat !== 35 || {QUOTIENT, REMAINDER} !== {32'd14, 32'd2}) begin
      fails++;
      $display("FAIL reset_mid_rerun lat=%0d q=%h r=%h want 35 14/2",
               lat, QUOTIENT, REMAINDER);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    RESET    = 1'b1;
    START    = 1'b0;
    SIGNED   = 1'b0;
    DIVIDEND = 32'd0;
    DIVISOR  = 32'd0;
    test_reset;
    test_unsigned;
    test_signed;
    test_corners;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/p405s_sm_div32_seq.md
# p405s_sm_div32_seq

Sequential 32-bit integer divider for the MAC/multiply-divide datapath. It is the inverse of the 33-bit carry-in/carry-out adder used for multiply-accumulate. A 33-bit add/subtract with carry-in runs one quotient bit per cycle (non-restoring). A single-pulse handshake starts a divide, and results are held until the next accepted START.

## Interface
Parameters:
- None. Width is fixed at 32-bit operands with a 33-bit partial remainder.

Ports:
- CB  input  1  clock. Single clock domain; all state changes on the rising edge.
- RESET  input  1  synchronous reset, active-high.
- START  input  1  request a divide. Sampled only when BUSY=0.
- SIGNED  input  1  1 = two's-complement divide; 0 = unsigned. Captured with START.
- DIVIDEND  input  32  captured with START.
- DIVISOR  input  32  captured with START.
- BUSY  output  1  divide in progress; START is ignored while high.
- DONE  output  1  one-cycle pulse; results are valid in this cycle and held afterward.
- QUOTIENT  output  32  result quotient.
- REMAINDER  output  32  result remainder.
- DIV_ZERO  output  1  the divisor was zero. Valid with DONE and held afterward.
- OVERFLOW  output  1  signed 0x80000000 / 0xFFFFFFFF. Valid with DONE and held afterward.

## Operation
- States:
  - IDLE: accepts START.
  - LOAD: 1 cycle.
  - ITER: 32 cycles, counted 0..31 by a 5-bit counter.
  - FIX: 1 cycle.
  - DONE: 1 cycle; accepts START.
- Transitions:
  - IDLE→LOAD on START.
  - LOAD→ITER.
  - ITER→FIX when the count reaches 31.
  - FIX→DONE.
  - DONE→LOAD if START is high; otherwise DONE→IDLE.
- LOAD:
  - Latches operand magnitudes. Negation applies only when SIGNED=1 and the operand's bit 31 is set.
  - Records the quotient sign (dividend sign XOR divisor sign) and the remainder sign (the dividend sign).
  - Flags divide-by-zero and overflow.
  - Clears the 33-bit partial remainder.
- ITER, each cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - If the partial remainder is non-negative (bit 32 = 0), add the inverted divisor with carry-in 1 (subtract). Otherwise, add the divisor with carry-in 0.
  - The new quotient bit is the inverse of the result's bit 32.
  - All adds are 33 bits wide; the carry out of bit 32 is discarded.
- FIX:
  - If the partial remainder is negative, add the divisor back.
  - Apply the recorded signs by two's-complement negation where set.
  - Load the QUOTIENT and REMAINDER registers.
- Signed results truncate toward zero. The remainder takes the sign of the dividend, or is 0.
- Divide by zero: latency is unchanged. QUOTIENT=0xFFFFFFFF, REMAINDER=DIVIDEND as captured, DIV_ZERO=1, OVERFLOW=0.
- Signed overflow (SIGNED=1, 0x80000000 / 0xFFFFFFFF): QUOTIENT=0x80000000, REMAINDER=0, OVERFLOW=1, DIV_ZERO=0.
- DIV_ZERO and OVERFLOW are never both 1.
- QUOTIENT, REMAINDER, DIV_ZERO and OVERFLOW change only in the FIX→DONE transition or on RESET. They are stable at all other times, including during a new divide.

## Timing
- Reset values: state=IDLE, BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV_ZERO=0, OVERFLOW=0, counter=0.
- RESET has priority over START in the same cycle.
- RESET in any state returns to IDLE at that edge and clears all outputs. An in-flight divide is discarded and produces no DONE.
- START sampled high at edge n (state IDLE or DONE):
  - BUSY is high in the cycles following edges n through n+33 (LOAD, ITER, FIX).
  - DONE is high in the cycle following edge n+34.
  - Total latency: 35 cycles from the START edge to DONE.
- BUSY and DONE are never high together.
- START while BUSY=1 is ignored; operands are not re-captured.
- Back-to-back: START held high in the DONE cycle begins the next divide. BUSY rises the next cycle, and the previous results stay on the outputs until the next FIX→DONE transition.
- Throughput: one divide per 35 cycles.

## Test plan
- Unsigned basic: START, SIGNED=0, 100 / 7 → DONE 35 cycles after the START edge, QUOTIENT=14, REMAINDER=2, both flags 0. BUSY is high for exactly 34 cycles.
- Signed mixed signs: −100 / 7 → QUOTIENT=0xFFFFFFF2, REMAINDER=0xFFFFFFFE. Also 100 / −7 → QUOTIENT=0xFFFFFFF2, REMAINDER=2.
- Corner values, SIGNED=0:
  - 0xFFFFFFFF / 1 → QUOTIENT=0xFFFFFFFF, REMAINDER=0.
  - 5 / 0 → QUOTIENT=0xFFFFFFFF, REMAINDER=5, DIV_ZERO=1.
  - Signed 0x80000000 / 0xFFFFFFFF → QUOTIENT=0x80000000, REMAINDER=0, OVERFLOW=1.
- START ignored while busy: a second START with 50 / 5 at cycle 10 of a 100 / 7 divide → only one DONE, carrying 14 / 2. No extra DONE follows.
- Back-to-back: START 100 / 7, then START 9 / 4 held during the DONE cycle → second DONE exactly 35 cycles after the first. QUOTIENT=2, REMAINDER=1; the outputs hold 14 / 2 until then.
- Reset mid-operation: RESET at cycle 20 of a divide → all outputs 0 and state IDLE on the next cycle, no DONE. A subsequent START 100 / 7 completes normally with 14 / 2.
